mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Shares one pipelined signed/unsigned n-bit multiplier between two requesters.
- Each requester issues operands plus a signed/unsigned mode bit over a valid/ready handshake.
- A round-robin arbiter grants at most one request per cycle.
- Each product is returned on the granting requester's result port after a fixed latency.
- Sits between two client datapaths and the multiplier, so clients need not be replicated.

Parameters:
- n, 8, operand width; product is 2n bits.
- lat, 2, result latency in cycles from acceptance to result valid; legal range lat >= 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  n  requester 0 operands.
- req0_signed  input  1  1 = two's-complement multiply, 0 = unsigned.
- req1_valid, req1_ready, req1_a, req1_b, req1_signed  as above, for requester 1.
- res0_valid  output  1  one-cycle pulse: res0 carries a requester 0 product.
- res0  output  2n  requester 0 product.
- res1_valid, res1  as above, for requester 1.
- idle  output  1  high when no operation is in flight.

Behaviour:
- Reset (rst_n low, async):
  - All pipeline valid bits are cleared; res0_valid = res1_valid = 0; res0 = res1 = 0; idle = 1.
  - The priority pointer selects requester 0.
- Acceptance: requester k's operation is accepted in cycle c iff reqk_valid && reqk_ready in cycle c.
- reqk_ready is combinational from both valids and the pointer:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester the pointer names is granted.
  - Neither valid: no grant.
  - At most one ready high per cycle. A ready is never high while its valid is low.
- Pointer update: on any grant, the pointer moves to the non-granted requester. With no grant it holds. Continuous contention therefore alternates 0,1,0,1...
- Requester rule: valid and operands must be held until accepted. The block never deasserts an already-asserted ready within a cycle and has no backpressure from the result side.
- Pipeline: operands, the mode bit and a 1-bit tag are captured at the acceptance edge. The product is computed and carried through the remaining lat-1 register stages.
- Latency: a result for an operation accepted in cycle c appears as resk_valid = 1 in cycle c+lat, for exactly one cycle.
- Throughput: one operation per cycle sustained. Back-to-back accepts from the same requester give back-to-back result pulses in order.
- Arithmetic:
  - signed = 1: both operands are interpreted as two's complement; the full 2n-bit product is exact (including min*min, e.g. n=4: -8*-8 = +64).
  - signed = 0: both operands are unsigned; the 2n-bit product is exact.
- resk holds its last delivered value between pulses and is not disturbed by the other requester's results.
- idle = 1 iff no accepted operation is still pending delivery. idle goes 0 in the cycle after an accept and returns to 1 in the cycle after the last result pulse.
- Boundary cases:
  - Simultaneous new valids: the pointer decides, the loser waits, and it is granted next cycle if still valid.
  - A requester whose valid drops before acceptance is not served, and the pointer is unaffected.
  - Reset mid-flight: all in-flight operations are discarded, and no resk_valid occurs for operations accepted before reset.
  - The first grant after reset under contention goes to requester 0.

Test Plan (n = 4, lat = 2):
- req0 unsigned a=15 b=15 accepted cycle c -> res0_valid in cycle c+2 only, res0 = 0xE1 (225); res1_valid stays 0.
- req1 signed a=4'b1000 b=4'b1000 -> res1 = 0x40 (+64). Then req1 signed a=4'b1000 b=4'b0111 -> res1 = 0xC8 (-56). Then req1 unsigned a=4'b1000 b=4'b0111 -> res1 = 0x38 (56).
- After reset, both valid held for 6 cycles with distinct operands:
  - Grants go 0,1,0,1,0,1, with exactly one ready per cycle.
  - Result pulses alternate res0/res1 two cycles after each grant, with correct products.
- Single requester 0 valid for 4 consecutive cycles, operands 1*1, 2*3, 5*5, 15*1 unsigned -> 4 consecutive res0_valid pulses with res0 = 1, 6, 25, 15; idle is 0 throughout and returns to 1 after the last pulse.
- Accept two ops, then assert rst_n low for 1 cycle before their results are due -> no res_valid pulse after release, res0 = res1 = 0, idle = 1; the next contended grant goes to requester 0.
- Exhaustive sweep: all 256 operand pairs in both modes via requester 0 while requester 1 issues random traffic -> every result matches a reference signed/unsigned 2n-bit product and routes to the correct port.

Source files
------------

// File: rtl/mul_share_arb.sv
// -----------------------------------------------------------------------------
// mul_share_arb
//
// Shares one pipelined n x n multiplier between two requesters. Each requester
// presents two operands and a signed/unsigned mode bit over valid/ready; a
// round-robin arbiter accepts at most one operation per cycle. The 2n-bit
// product comes back on the accepted requester's result port exactly `lat`
// cycles after acceptance, as a one-cycle valid pulse.
//
// Parameters
//   n    operand width (product is 2n bits)
//   lat  acceptance-to-result latency in cycles, lat >= 1
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqK_valid / reqK_ready          request handshake, K = 0,1
//   reqK_a, reqK_b                   operands (n bits)
//   reqK_signed                      1 = two's complement, 0 = unsigned
//   resK_valid                       one-cycle pulse, resK carries a new product
//   resK                             product (2n bits), holds between pulses
//   idle                             no accepted operation awaiting delivery
// -----------------------------------------------------------------------------
module mul_share_arb #(
  parameter int n   = 8,
  parameter int lat = 2
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic         req0_signed,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  input  logic         req1_signed,

  output logic           res0_valid,
  output logic [2*n-1:0] res0,
  output logic           res1_valid,
  output logic [2*n-1:0] res1,

  output logic         idle
);

  localparam int w = 2 * n;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. ptr names the requester that wins a tie
  // (0 = requester 0). Grants depend only on the valids and ptr, so a ready
  // never drops within a cycle while the valids are stable.
  // ---------------------------------------------------------------------------
  logic ptr;
  logic grant0;
  logic grant1;
  logic accept;

  // NOTE: combinational logic uses blocking '=' and assigns every output
  // before any condition, so no path leaves a signal unassigned (no latch).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = !ptr;
      grant1 = ptr;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // Stage 0: operand capture at the acceptance edge. tag = requester index.
  // ---------------------------------------------------------------------------
  logic         s0_valid;
  logic         s0_tag;
  logic [n-1:0] s0_a;
  logic [n-1:0] s0_b;
  logic         s0_signed;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      s0_valid <= 1'b0;
    end else begin
      // The loser of this cycle gets priority next; no grant leaves ptr alone.
      if (grant0) begin
        ptr <= 1'b1;
      end else if (grant1) begin
        ptr <= 1'b0;
      end
      s0_valid <= accept;
    end
  end

  // NOTE: datapath registers are deliberately not reset; every consumer is
  // qualified by a valid bit that is reset, so their contents never escape.
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_tag    <= grant1;
      s0_a      <= grant1 ? req1_a      : req0_a;
      s0_b      <= grant1 ? req1_b      : req0_b;
      s0_signed <= grant1 ? req1_signed : req0_signed;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply. Both operands are sign- or zero-extended to 2n bits and
  // multiplied modulo 2^2n. The exact product of two n-bit numbers (either
  // interpretation, including min*min) always fits in 2n bits, so the
  // truncated result is exact and no separate signed multiplier is needed.
  // ---------------------------------------------------------------------------
  logic [w-1:0] a_ext;
  logic [w-1:0] b_ext;
  logic [w-1:0] prod_c;

  always_comb begin
    a_ext  = {{n{s0_signed & s0_a[n-1]}}, s0_a};
    b_ext  = {{n{s0_signed & s0_b[n-1]}}, s0_b};
    prod_c = a_ext * b_ext;
  end

  // ---------------------------------------------------------------------------
  // Remaining lat-1 stages carry the product, its tag and valid bit. The
  // last stage (or stage 0 itself when lat = 1) drives the result ports.
  // ---------------------------------------------------------------------------
  logic         fin_valid;
  logic         fin_tag;
  logic [w-1:0] fin_prod;
  logic         tail_busy;

  if (lat == 1) begin : g_direct
    assign fin_valid = s0_valid;
    assign fin_tag   = s0_tag;
    assign fin_prod  = prod_c;
    assign tail_busy = 1'b0;
  end else begin : g_pipe
    logic [lat-1:1] pv;
    logic [lat-1:1] pt;
    logic [w-1:0]   pp [1:lat-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
      end else begin
        pv[1] <= s0_valid;
        for (int i = 2; i < lat; i++) begin
          pv[i] <= pv[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      pt[1] <= s0_tag;
      pp[1] <= prod_c;
      for (int i = 2; i < lat; i++) begin
        pt[i] <= pt[i-1];
        pp[i] <= pp[i-1];
      end
    end

    assign fin_valid = pv[lat-1];
    assign fin_tag   = pt[lat-1];
    assign fin_prod  = pp[lat-1];
    assign tail_busy = |pv;
  end

  // ---------------------------------------------------------------------------
  // Result routing. During a pulse the port shows the fresh product directly;
  // otherwise it shows the value captured at its own last pulse, so results
  // for the other requester never disturb it.
  // ---------------------------------------------------------------------------
  logic [w-1:0] res0_q;
  logic [w-1:0] res1_q;

  assign res0_valid = fin_valid && !fin_tag;
  assign res1_valid = fin_valid &&  fin_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res0_q <= '0;
      res1_q <= '0;
    end else begin
      if (res0_valid) begin
        res0_q <= fin_prod;
      end
      if (res1_valid) begin
        res1_q <= fin_prod;
      end
    end
  end

  assign res0 = res0_valid ? fin_prod : res0_q;
  assign res1 = res1_valid ? fin_prod : res1_q;

  // An operation is pending from the cycle after acceptance up to and
  // including its result pulse.
  assign idle = !(s0_valid || tail_busy);

endmodule

// File: tb/tb_mul_share_arb.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arb
//
// Self-checking bench for mul_share_arb at n = 4, lat = 2. A table of
// per-cycle vectors (inputs, expected readies, expected product of the
// accepted operation) drives the single-op and contention scenarios; the
// burst, mid-flight reset and operand sweep are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mul_share_arb;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic           clk;
  logic           rst_n;
  logic           req0_valid;
  logic           req0_ready;
  logic [N-1:0]   req0_a;
  logic [N-1:0]   req0_b;
  logic           req0_signed;
  logic           req1_valid;
  logic           req1_ready;
  logic [N-1:0]   req1_a;
  logic [N-1:0]   req1_b;
  logic           req1_signed;
  logic           res0_valid;
  logic [2*N-1:0] res0;
  logic           res1_valid;
  logic [2*N-1:0] res1;
  logic           idle;

  mul_share_arb #(.n(N), .lat(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_signed (req0_signed),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_signed (req1_signed),
    .res0_valid  (res0_valid),
    .res0        (res0),
    .res1_valid  (res1_valid),
    .res1        (res1),
    .idle        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product, computed from integer arithmetic.
  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x;
    int y;
    int p;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    p = x * y;
    return p[7:0];
  endfunction

  typedef struct {
    logic       v0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       s0;
    logic       v1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       s1;
    logic       g0;
    logic       g1;
    logic [7:0] p;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                              input logic s0, input logic v1, input logic [3:0] a1,
                              input logic [3:0] b1, input logic s1, input logic g0,
                              input logic g1, input logic [7:0] p);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.s0 = s0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.s1 = s1;
    v.g0 = g0; v.g1 = g1; v.p = p;
    return v;
  endfunction

  vec_t vecs [19];

  logic [7:0] exp_res0;
  logic [7:0] exp_res1;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic idle_inputs();
    req0_valid  = 1'b0;
    req0_a      = '0;
    req0_b      = '0;
    req0_signed = 1'b0;
    req1_valid  = 1'b0;
    req1_a      = '0;
    req1_b      = '0;
    req1_signed = 1'b0;
  endtask

  // Reset pulse; returns 1 time unit after a rising edge.
  task automatic do_reset();
    idle_inputs();
    rst_n    = 1'b0;
    exp_res0 = '0;
    exp_res1 = '0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Applies table rows lo..hi, one per cycle. Entered and left 1 time unit
  // after a rising edge. Results of row i-2 are due during row i.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      logic e0;
      logic e1;
      e0 = 1'b0;
      e1 = 1'b0;
      if (i - 2 >= lo) begin
        e0 = vecs[i-2].g0;
        e1 = vecs[i-2].g1;
        if (e0) exp_res0 = vecs[i-2].p;
        if (e1) exp_res1 = vecs[i-2].p;
      end
      check($sformatf("row%0d res0_valid", i), 16'(res0_valid), 16'(e0));
      check($sformatf("row%0d res1_valid", i), 16'(res1_valid), 16'(e1));
      check($sformatf("row%0d res0", i), 16'(res0), 16'(exp_res0));
      check($sformatf("row%0d res1", i), 16'(res1), 16'(exp_res1));
      req0_valid  = vecs[i].v0;
      req0_a      = vecs[i].a0;
      req0_b      = vecs[i].b0;
      req0_signed = vecs[i].s0;
      req1_valid  = vecs[i].v1;
      req1_a      = vecs[i].a1;
      req1_b      = vecs[i].b1;
      req1_signed = vecs[i].s1;
      #1;
      check($sformatf("row%0d req0_ready", i), 16'(req0_ready), 16'(vecs[i].g0));
      check($sformatf("row%0d req1_ready", i), 16'(req1_ready), 16'(vecs[i].g1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sweep_results();
    logic [7:0] e;
    if (res0_valid) begin
      if (q0.size() == 0) begin
        check("sweep res0 spurious pulse", 16'(res0_valid), 16'h0);
      end else begin
        e = q0.pop_front();
        check("sweep res0", 16'(res0), 16'(e));
      end
    end
    if (res1_valid) begin
      if (q1.size() == 0) begin
        check("sweep res1 spurious pulse", 16'(res1_valid), 16'h0);
      end else begin
        e = q1.pop_front();
        check("sweep res1", 16'(res1), 16'(e));
      end
    end
  endtask

  initial begin
    logic [3:0] ba [4];
    logic [3:0] bb [4];
    logic [7:0] bp [4];
    int         idx;
    int         cycles;
    logic       hold1;
    logic [8:0] op;

    //            v0    a0    b0    s0    v1    a1    b1    s1    g0    g1    p
    // Single operations on each port, both modes.
    vecs[0]  = mk(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hE1);
    vecs[1]  = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[2]  = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[3]  = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h8, 4'h8, 1'b1, 1'b0, 1'b1, 8'h40);
    vecs[4]  = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h8, 4'h7, 1'b1, 1'b0, 1'b1, 8'hC8);
    vecs[5]  = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h8, 4'h7, 1'b0, 1'b0, 1'b1, 8'h38);
    vecs[6]  = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[7]  = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    // Contention after reset: 0,1,0,1,0,1; then req0 drops unserved, the
    // pointer still favours req0, then req1 alone.
    vecs[8]  = mk(1'b1, 4'h1, 4'h2, 1'b0, 1'b1, 4'h2, 4'h5, 1'b0, 1'b1, 1'b0, 8'h02);
    vecs[9]  = mk(1'b1, 4'h3, 4'h3, 1'b0, 1'b1, 4'h2, 4'h5, 1'b0, 1'b0, 1'b1, 8'h0A);
    vecs[10] = mk(1'b1, 4'h3, 4'h3, 1'b0, 1'b1, 4'h7, 4'h7, 1'b0, 1'b1, 1'b0, 8'h09);
    vecs[11] = mk(1'b1, 4'hF, 4'h2, 1'b0, 1'b1, 4'h7, 4'h7, 1'b0, 1'b0, 1'b1, 8'h31);
    vecs[12] = mk(1'b1, 4'hF, 4'h2, 1'b0, 1'b1, 4'hF, 4'h2, 1'b1, 1'b1, 1'b0, 8'h1E);
    vecs[13] = mk(1'b1, 4'h9, 4'h9, 1'b0, 1'b1, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 8'hFE);
    vecs[14] = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[15] = mk(1'b1, 4'h4, 4'h4, 1'b0, 1'b1, 4'h3, 4'h3, 1'b0, 1'b1, 1'b0, 8'h10);
    vecs[16] = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0, 1'b1, 8'h09);
    vecs[17] = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[18] = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);

    ba = '{4'h1, 4'h2, 4'h5, 4'hF};
    bb = '{4'h1, 4'h3, 4'h5, 4'h1};
    bp = '{8'h01, 8'h06, 8'h19, 8'h0F};

    // ---- reset state ----
    idle_inputs();
    rst_n    = 1'b0;
    exp_res0 = '0;
    exp_res1 = '0;
    #1;
    check("reset res0_valid", 16'(res0_valid), 16'h0);
    check("reset res1_valid", 16'(res1_valid), 16'h0);
    check("reset res0", 16'(res0), 16'h0);
    check("reset res1", 16'(res1), 16'h0);
    check("reset idle", 16'(idle), 16'h1);
    check("reset req0_ready", 16'(req0_ready), 16'h0);
    check("reset req1_ready", 16'(req1_ready), 16'h0);
    do_reset();

    // ---- single ops, then contention from a fresh reset ----
    run_rows(0, 7);
    do_reset();
    run_rows(8, 18);

    // ---- back-to-back burst on requester 0 ----
    for (int t = 0; t < 8; t++) begin
      logic ev;
      ev = (t >= 2) && (t <= 5);
      if (ev) exp_res0 = bp[t-2];
      check($sformatf("burst t%0d res0_valid", t), 16'(res0_valid), 16'(ev));
      check($sformatf("burst t%0d res0", t), 16'(res0), 16'(exp_res0));
      check($sformatf("burst t%0d idle", t), 16'(idle), 16'((t == 0) || (t >= 6)));
      if (t < 4) begin
        req0_valid  = 1'b1;
        req0_a      = ba[t];
        req0_b      = bb[t];
        req0_signed = 1'b0;
      end else begin
        req0_valid = 1'b0;
      end
      #1;
      check($sformatf("burst t%0d req0_ready", t), 16'(req0_ready), 16'(t < 4));
      @(posedge clk);
      #1;
    end

    // ---- reset with two operations in flight ----
    req1_valid = 1'b1; req1_a = 4'h5; req1_b = 4'h5; req1_signed = 1'b0;
    #1;
    check("midrst accept req1", 16'(req1_ready), 16'h1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h3; req0_signed = 1'b0;
    #1;
    check("midrst accept req0", 16'(req0_ready), 16'h1);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n    = 1'b0;
    exp_res0 = '0;
    exp_res1 = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrst t%0d res0_valid", t), 16'(res0_valid), 16'h0);
      check($sformatf("midrst t%0d res1_valid", t), 16'(res1_valid), 16'h0);
      check($sformatf("midrst t%0d res0", t), 16'(res0), 16'h0);
      check($sformatf("midrst t%0d res1", t), 16'(res1), 16'h0);
      check($sformatf("midrst t%0d idle", t), 16'(idle), 16'h1);
    end
    req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h3; req0_signed = 1'b0;
    req1_valid = 1'b1; req1_a = 4'h4; req1_b = 4'h5; req1_signed = 1'b0;
    #1;
    check("post-reset contention req0_ready", 16'(req0_ready), 16'h1);
    check("post-reset contention req1_ready", 16'(req1_ready), 16'h0);
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    check("post-reset result valid", 16'(res0_valid), 16'h1);
    check("post-reset result", 16'(res0), 16'h06);
    @(posedge clk);
    #1;

    // ---- operand sweep on requester 0 with random requester 1 traffic ----
    idx    = 0;
    cycles = 0;
    hold1  = 1'b0;
    while (idx < 512 && cycles < 3000) begin
      sweep_results();
      op          = 9'(idx);
      req0_valid  = 1'b1;
      req0_signed = op[8];
      req0_a      = op[7:4];
      req0_b      = op[3:0];
      if (!hold1) begin
        if ($urandom_range(0, 2) != 0) begin
          req1_valid  = 1'b1;
          req1_a      = 4'($urandom_range(0, 15));
          req1_b      = 4'($urandom_range(0, 15));
          req1_signed = 1'($urandom_range(0, 1));
          hold1       = 1'b1;
        end else begin
          req1_valid = 1'b0;
        end
      end
      #1;
      if (req0_ready && req1_ready) begin
        check("sweep one ready per cycle", 16'(req0_ready & req1_ready), 16'h0);
      end
      if (req0_ready) begin
        q0.push_back(ref_mul(req0_a, req0_b, req0_signed));
        idx++;
      end
      if (req1_ready) begin
        q1.push_back(ref_mul(req1_a, req1_b, req1_signed));
        hold1 = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    check("sweep all ops accepted", 16'(idx), 16'd512);
    idle_inputs();
    for (int t = 0; t < 4; t++) begin
      sweep_results();
      @(posedge clk);
      #1;
    end
    check("sweep res0 queue drained", 16'(q0.size()), 16'h0);
    check("sweep res1 queue drained", 16'(q1.size()), 16'h0);
    check("sweep idle at end", 16'(idle), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
